// File: rtl/mac_pkg.sv
// Shared widths, mac pipeline timing and sequencer types for the dot-product sequencer.
package mac_pkg;

   localparam int unsigned OP_W          = 16;
   localparam int unsigned ACC_W         = 32;
   localparam int unsigned MAC_LAT       = 5;
   localparam int unsigned MAC_ADD_STAGE = 3;

   typedef enum logic [1:0] {
      StRun   = 2'd0,
      StDrain = 2'd1,
      StHold  = 2'd2
   } state_e;

   typedef struct packed {
      logic vld;
      logic first;
      logic last;
   } tag_t;

endpackage

// File: rtl/mac_tag_pipe.sv
// Shift register of element tags running alongside the mac pipeline.
module mac_tag_pipe
   import mac_pkg::*;
#(
   parameter int unsigned DEPTH = MAC_LAT,
   parameter int unsigned TAP_A = MAC_ADD_STAGE,
   parameter int unsigned TAP_B = MAC_LAT
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  tag_t i_tag,
   output tag_t o_tap_a,
   output tag_t o_tap_b
);

   // Index k holds the tag of the element currently in mac stage k.
   tag_t [DEPTH:1] r_stage;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_stage <= '0;
      end else begin
         r_stage <= {r_stage[DEPTH-1:1], i_tag};
      end
   end

   assign o_tap_a = r_stage[TAP_A];
   assign o_tap_b = r_stage[TAP_B];

endmodule

// File: rtl/mac_dot_seq.sv
// Streaming dot-product sequencer: issues element pairs to a 5-stage mac and steers its
// accumulator feedback, returning one 32-bit sum per vector.
module mac_dot_seq
   import mac_pkg::*;
#(
   parameter int unsigned LEN_W = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_s_valid,
   output logic             o_s_ready,
   input  logic [OP_W-1:0]  i_s_a,
   input  logic [OP_W-1:0]  i_s_b,
   input  logic             i_s_last,
   output logic [OP_W-1:0]  o_mac_a,
   output logic [OP_W-1:0]  o_mac_b,
   output logic [ACC_W-1:0] o_mac_acc_in,
   input  logic [ACC_W-1:0] i_mac_acc_out,
   output logic             o_m_valid,
   input  logic             i_m_ready,
   output logic [ACC_W-1:0] o_m_result,
   output logic [LEN_W-1:0] o_m_count
);

   state_e             r_state;
   logic               r_acc_prev;
   logic               r_first_pend;
   logic [LEN_W-1:0]   r_count;
   logic [OP_W-1:0]    r_mac_a;
   logic [OP_W-1:0]    r_mac_b;
   tag_t               r_iss;
   logic [ACC_W-1:0]   r_psum;
   logic               r_m_valid;
   logic [ACC_W-1:0]   r_m_result;
   logic [LEN_W-1:0]   r_m_count;

   logic w_accept;
   tag_t w_s3;
   tag_t w_s5;
   logic w_unused;

   // Back-to-back accepts are blocked so consecutive elements sit 2 mac cycles apart.
   assign o_s_ready = (r_state == StRun) && !r_acc_prev;
   assign w_accept  = i_s_valid && o_s_ready;

   mac_tag_pipe #(
      .DEPTH(MAC_LAT),
      .TAP_A(MAC_ADD_STAGE),
      .TAP_B(MAC_LAT)
   ) u_tag_pipe (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_tag  (r_iss),
      .o_tap_a(w_s3),
      .o_tap_b(w_s5)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= StRun;
         r_acc_prev   <= 1'b0;
         r_first_pend <= 1'b1;
         r_count      <= '0;
         r_mac_a      <= '0;
         r_mac_b      <= '0;
         r_iss        <= '0;
         r_psum       <= '0;
         r_m_valid    <= 1'b0;
         r_m_result   <= '0;
         r_m_count    <= '0;
      end else begin
         r_acc_prev  <= w_accept;
         r_mac_a     <= w_accept ? i_s_a : '0;
         r_mac_b     <= w_accept ? i_s_b : '0;
         r_iss.vld   <= w_accept;
         r_iss.first <= w_accept && r_first_pend;
         r_iss.last  <= w_accept && i_s_last;
         if (w_s5.vld) begin
            r_psum <= i_mac_acc_out;
         end
         unique case (r_state)
            StRun: begin
               if (w_accept) begin
                  r_count      <= r_count + LEN_W'(1);
                  r_first_pend <= 1'b0;
                  if (i_s_last) begin
                     r_state <= StDrain;
                  end
               end
            end
            StDrain: begin
               if (w_s5.vld && w_s5.last) begin
                  r_m_result <= i_mac_acc_out;
                  r_m_count  <= r_count;
                  r_m_valid  <= 1'b1;
                  r_state    <= StHold;
               end
            end
            StHold: begin
               if (r_m_valid && i_m_ready) begin
                  r_m_valid    <= 1'b0;
                  r_count      <= '0;
                  r_first_pend <= 1'b1;
                  r_state      <= StRun;
               end
            end
            default: r_state <= StRun;
         endcase
      end
   end

   // Feedback into the adder: zero for the first element, bypass when the previous sum
   // is emerging this very cycle, otherwise the stored partial sum.
   always_comb begin
      o_mac_acc_in = '0;
      if (w_s3.vld && !w_s3.first) begin
         o_mac_acc_in = w_s5.vld ? i_mac_acc_out : r_psum;
      end
   end

   assign w_unused = ^{w_s3.last, w_s5.first};

   assign o_mac_a    = r_mac_a;
   assign o_mac_b    = r_mac_b;
   assign o_m_valid  = r_m_valid;
   assign o_m_result = r_m_result;
   assign o_m_count  = r_m_count;

endmodule

// File: tb/tb_mac_dot_seq.sv
// Self-checking bench for mac_dot_seq with a behavioural 5-stage mac attached.
module tb_mac_dot_seq;

   logic        clk;
   logic        rst_n;
   logic        s_valid;
   logic        s_ready;
   logic [15:0] s_a;
   logic [15:0] s_b;
   logic        s_last;
   logic [15:0] mac_a;
   logic [15:0] mac_b;
   logic [31:0] mac_acc_in;
   logic [31:0] mac_acc_out;
   logic        m_valid;
   logic        m_ready;
   logic [31:0] m_result;
   logic [7:0]  m_count;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   logic [15:0] va[$];
   logic [15:0] vb[$];
   int          acc_cyc[$];

   typedef struct {
      int          c;
      logic [15:0] a;
      logic [15:0] b;
   } issue_t;
   issue_t      issue_q[$];
   logic [31:0] acc_log[int];
   logic        rdy_log[int];

   mac_dot_seq #(.LEN_W(8)) u_dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_s_valid    (s_valid),
      .o_s_ready    (s_ready),
      .i_s_a        (s_a),
      .i_s_b        (s_b),
      .i_s_last     (s_last),
      .o_mac_a      (mac_a),
      .o_mac_b      (mac_b),
      .o_mac_acc_in (mac_acc_in),
      .i_mac_acc_out(mac_acc_out),
      .o_m_valid    (m_valid),
      .i_m_ready    (m_ready),
      .o_m_result   (m_result),
      .o_m_count    (m_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Environment mac: product in c, adder samples acc_in in c+3, sum out in c+5.
   logic [31:0] p1, p2, p3, s4, s5;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p1 <= '0; p2 <= '0; p3 <= '0; s4 <= '0; s5 <= '0;
      end else begin
         p1 <= {16'h0, mac_a} * {16'h0, mac_b};
         p2 <= p1;
         p3 <= p2;
         s4 <= p3 + mac_acc_in;
         s5 <= s4;
      end
   end
   assign mac_acc_out = s5;

   initial begin
      forever begin
         @(negedge clk);
         acc_log[cyc] = mac_acc_in;
         rdy_log[cyc] = s_ready;
         if (mac_a != 16'h0 || mac_b != 16'h0) issue_q.push_back('{cyc, mac_a, mac_b});
      end
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] ref_dot();
      logic [31:0] sum = 32'h0;
      for (int i = 0; i < va.size(); i++) sum += {16'h0, va[i]} * {16'h0, vb[i]};
      return sum;
   endfunction

   task automatic drive_vec(input int gap_lo, input int gap_hi);
      acc_cyc.delete();
      for (int i = 0; i < va.size(); i++) begin
         int guard = 0;
         s_valid = 1'b1;
         s_a     = va[i];
         s_b     = vb[i];
         s_last  = (i == va.size() - 1);
         while (!s_ready && guard < 20) begin
            step();
            guard++;
         end
         acc_cyc.push_back(s_ready ? cyc : -1);
         step();
         s_valid = 1'b0;
         s_a     = 16'($urandom);
         s_b     = 16'($urandom);
         s_last  = 1'($urandom_range(0, 1));
         if (i != va.size() - 1) begin
            int gap = $urandom_range(gap_hi, gap_lo);
            for (int g = 0; g < gap; g++) step();
         end
      end
      s_last = 1'b0;
   endtask

   task automatic wait_mvalid(output int vc);
      vc = -1;
      for (int k = 0; k < 40; k++) begin
         if (m_valid) begin
            vc = cyc;
            break;
         end
         step();
      end
   endtask

   task automatic consume;
      m_ready = 1'b1;
      step();
      m_ready = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; s_valid = 1'b0; s_a = '0; s_b = '0; s_last = 1'b0; m_ready = 1'b0;
      step();
      step();
      n_checks++;
      if ({s_ready, m_valid, mac_a, mac_b, mac_acc_in, m_result, m_count} !==
          {1'b1, 1'b0, 16'h0, 16'h0, 32'h0, 32'h0, 8'h0}) begin
         $display("FAIL reset_values: got rdy=%0b mv=%0b a=%0h b=%0h acc=%0h res=%0h cnt=%0h, want rdy=1 others 0",
                  s_ready, m_valid, mac_a, mac_b, mac_acc_in, m_result, m_count);
      end else n_pass++;
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_single;
      int vc;
      va = '{16'd3}; vb = '{16'd4};
      issue_q.delete();
      drive_vec(0, 0);
      wait_mvalid(vc);
      n_checks++;
      if (vc !== acc_cyc[0] + 7) $display("FAIL single_latency: got cycle %0d want %0d", vc, acc_cyc[0] + 7);
      else n_pass++;
      n_checks++;
      if ({m_result, m_count} !== {32'd12, 8'd1})
         $display("FAIL single_result: got %0d/%0d want 12/1", m_result, m_count);
      else n_pass++;
      n_checks++;
      if (issue_q.size() !== 1 || issue_q[0].c !== acc_cyc[0] + 1 || issue_q[0].a !== 16'd3 ||
          issue_q[0].b !== 16'd4)
         $display("FAIL single_issue: got %0d issue cycles, want one at %0d with a=3 b=4",
                  issue_q.size(), acc_cyc[0] + 1);
      else n_pass++;
      consume();
   endtask

   task automatic test_back_to_back;
      int vc;
      int t0;
      va = '{16'd1, 16'd2, 16'd3}; vb = '{16'd4, 16'd5, 16'd6};
      drive_vec(0, 0);
      t0 = acc_cyc[0];
      wait_mvalid(vc);
      n_checks++;
      if (acc_cyc[1] !== t0 + 2 || acc_cyc[2] !== t0 + 4)
         $display("FAIL b2b_accepts: got %0d,%0d want %0d,%0d", acc_cyc[1], acc_cyc[2], t0 + 2, t0 + 4);
      else n_pass++;
      n_checks++;
      if ({rdy_log[t0 + 1], rdy_log[t0 + 3], rdy_log[t0 + 5], rdy_log[t0 + 8]} !== 4'b0000)
         $display("FAIL b2b_ready_low: got %0b%0b%0b%0b want 0000", rdy_log[t0 + 1], rdy_log[t0 + 3],
                  rdy_log[t0 + 5], rdy_log[t0 + 8]);
      else n_pass++;
      n_checks++;
      if (vc !== t0 + 11) $display("FAIL b2b_latency: got cycle %0d want %0d", vc, t0 + 11);
      else n_pass++;
      n_checks++;
      if ({m_result, m_count} !== {32'd32, 8'd3})
         $display("FAIL b2b_result: got %0d/%0d want 32/3", m_result, m_count);
      else n_pass++;
      consume();
   endtask

   task automatic test_psum_path;
      int vc;
      va = '{16'd1, 16'd2, 16'd3}; vb = '{16'd4, 16'd5, 16'd6};
      drive_vec(5, 5);
      wait_mvalid(vc);
      n_checks++;
      if ({acc_log[acc_cyc[0] + 4], acc_log[acc_cyc[1] + 4], acc_log[acc_cyc[2] + 4]} !==
          {32'd0, 32'd4, 32'd14})
         $display("FAIL psum_acc_in: got %0d,%0d,%0d want 0,4,14", acc_log[acc_cyc[0] + 4],
                  acc_log[acc_cyc[1] + 4], acc_log[acc_cyc[2] + 4]);
      else n_pass++;
      n_checks++;
      if ({m_result, m_count} !== {32'd32, 8'd3})
         $display("FAIL psum_result: got %0d/%0d want 32/3", m_result, m_count);
      else n_pass++;
      consume();
   endtask

   task automatic test_wrap;
      int vc;
      va = '{16'hFFFF, 16'hFFFF}; vb = '{16'hFFFF, 16'hFFFF};
      drive_vec(0, 2);
      wait_mvalid(vc);
      n_checks++;
      if ({m_result, m_count} !== {32'hFFFC0002, 8'd2})
         $display("FAIL wrap_result: got %0h/%0d want fffc0002/2", m_result, m_count);
      else n_pass++;
      consume();
   endtask

   task automatic test_backpressure;
      int vc;
      int bad = 0;
      va = '{16'd10, 16'd20}; vb = '{16'd3, 16'd4};
      drive_vec(0, 1);
      wait_mvalid(vc);
      for (int k = 0; k < 10; k++) begin
         if (m_valid !== 1'b1 || m_result !== 32'd110 || m_count !== 8'd2 || s_ready !== 1'b0) bad++;
         step();
      end
      n_checks++;
      if (bad !== 0) $display("FAIL bp_hold: got %0d unstable cycles want 0", bad);
      else n_pass++;
      consume();
      n_checks++;
      if ({m_valid, s_ready} !== 2'b01)
         $display("FAIL bp_release: got m_valid=%0b s_ready=%0b want 0/1", m_valid, s_ready);
      else n_pass++;
      va = '{16'd7}; vb = '{16'd6};
      drive_vec(0, 0);
      wait_mvalid(vc);
      n_checks++;
      if ({m_result, m_count} !== {32'd42, 8'd1})
         $display("FAIL bp_next_vector: got %0d/%0d want 42/1", m_result, m_count);
      else n_pass++;
      consume();
   endtask

   task automatic test_reset_mid;
      int vc;
      int bad = 0;
      va = '{16'd9}; vb = '{16'd9};
      drive_vec(0, 0);
      step();
      step();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      n_checks++;
      if (s_ready !== 1'b1) $display("FAIL rst_mid_ready: got %0b want 1", s_ready);
      else n_pass++;
      for (int k = 0; k < 12; k++) begin
         if (m_valid !== 1'b0) bad++;
         step();
      end
      n_checks++;
      if (bad !== 0) $display("FAIL rst_mid_no_result: got %0d m_valid cycles want 0", bad);
      else n_pass++;
      va = '{16'd2}; vb = '{16'd5};
      drive_vec(0, 0);
      wait_mvalid(vc);
      n_checks++;
      if ({m_result, m_count} !== {32'd10, 8'd1} || vc !== acc_cyc[0] + 7)
         $display("FAIL rst_mid_after: got %0d/%0d at %0d want 10/1 at %0d", m_result, m_count, vc,
                  acc_cyc[0] + 7);
      else n_pass++;
      consume();
   endtask

   task automatic test_random;
      int          vc;
      int          len;
      logic [31:0] exp_sum;
      for (int v = 0; v < 8; v++) begin
         len = $urandom_range(6, 1);
         va.delete(); vb.delete();
         for (int i = 0; i < len; i++) begin
            va.push_back(16'($urandom));
            vb.push_back(16'($urandom));
         end
         exp_sum = ref_dot();
         drive_vec(0, 3);
         wait_mvalid(vc);
         n_checks++;
         if ({m_result, m_count} !== {exp_sum, 8'(len)} || vc !== acc_cyc[len - 1] + 7)
            $display("FAIL rand_vec%0d: got %0h/%0d at %0d want %0h/%0d at %0d", v, m_result, m_count,
                     vc, exp_sum, len, acc_cyc[len - 1] + 7);
         else n_pass++;
         for (int d = $urandom_range(3, 0); d > 0; d--) step();
         consume();
      end
   endtask

   task automatic test_count_wrap;
      int          vc;
      logic [31:0] exp_sum;
      va.delete(); vb.delete();
      for (int i = 0; i < 257; i++) begin
         va.push_back(16'($urandom));
         vb.push_back(16'($urandom));
      end
      exp_sum = ref_dot();
      drive_vec(0, 0);
      wait_mvalid(vc);
      n_checks++;
      if ({m_result, m_count} !== {exp_sum, 8'd1})
         $display("FAIL count_wrap: got %0h/%0d want %0h/1", m_result, m_count, exp_sum);
      else n_pass++;
      consume();
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_psum_path();
      test_wrap();
      test_backpressure();
      test_reset_mid();
      test_random();
      test_count_wrap();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mac_dot_seq.md
Name: mac_dot_seq

Overview:
- Streaming dot-product sequencer that drives the mac block's operand and accumulator ports.
- Accepts (a, b) element pairs over a valid/ready stream.
- Closes the accumulation loop by steering mac acc_out back into acc_in.
- Returns one 32-bit sum per vector on an output valid/ready stream. Sits between the operand source and the mac.

Parameters:
- LEN_W, 8, width of element counter m_count (wraps modulo 2^LEN_W)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset; 0 = reset
- s_valid  in  1  element valid
- s_ready  out  1  element accepted when s_valid&s_ready at rising edge
- s_a  in  16  multiplicand, unsigned
- s_b  in  16  multiplier, unsigned
- s_last  in  1  final element of vector
- mac_a  out  16  to mac a
- mac_b  out  16  to mac b
- mac_acc_in  out  32  to mac acc_in
- mac_acc_out  in  32  from mac acc_out
- m_valid  out  1  result valid
- m_ready  in  1  result consumed when m_valid&m_ready
- m_result  out  32  dot product, modulo 2^32
- m_count  out  LEN_W  elements in vector

Behaviour:
Reset values: all outputs 0 except s_ready (1); state RUN; tag pipe, psum and counter cleared.

mac timing model (fixed):
- Element held on mac_a/mac_b in cycle c.
- Adder samples acc_in in cycle c+3.
- Sum visible on mac_acc_out in cycle c+5.

Issue rules:
- Accepted element is registered onto mac_a/mac_b, i.e. issued in the cycle after acceptance.
- mac_a/mac_b = 0 in every non-issue cycle.

Tag pipe:
- 5-deep shift of {valid, first, last}; stage k = element at mac stage k.
- Advances every cycle; stage 1 is loaded on issue.
- first = first element after RUN entry.

Accumulator steering, in cycle where stage-3 tag is valid:
- first=1 -> acc_in = 0.
- Else, if stage-5 tag valid -> acc_in = mac_acc_out (bypass, 2-cycle spacing).
- Else -> acc_in = psum.
- Other cycles: acc_in = 0.
- psum <= mac_acc_out whenever stage-5 tag is valid.

States:
- RUN: s_ready = 1 unless an element was accepted the previous cycle. Minimum spacing 2 cycles; max throughput 1 element / 2 cycles. Each accept increments the counter. Accept with s_last=1 -> DRAIN.
- DRAIN: s_ready = 0. When the stage-5 tag has last=1: m_result <= mac_acc_out, m_count <= counter, m_valid <= 1, state -> HOLD.
- HOLD: s_ready = 0; m_result/m_count stable. On m_valid&m_ready: m_valid <= 0, counter <= 0, state -> RUN, s_ready = 1 the following cycle.

Latency: accept of last element in cycle 0 -> m_valid high in cycle 7.

Arithmetic: unsigned 16x16 product; sum wraps modulo 2^32; no saturation or overflow flag.

Boundaries:
- Single-element vector is legal (first=last=1).
- Counter wraps at 2^LEN_W.
- s_valid without s_ready: inputs ignored, no state change.
- s_last only meaningful on an accepted beat.

Reset mid-operation:
- Immediate clear of all tags, psum, counter and m_valid.
- In-flight mac data is discarded: no tag references it.
- The mac's own reset (active-high) is tied to ~rst at integration level.

Decomposition:
- Shared header/package mac_pkg: OP_W=16, ACC_W=32, MAC_LAT=5, MAC_ADD_STAGE=3, state encodings RUN/DRAIN/HOLD.
- One sub-module: mac_tag_pipe, a parameterised-depth shift register of {valid, first, last}. It exposes stage 3 and stage 5 taps and has async active-low clear.

Test Plan:
1. Single element a=3, b=4, last, accepted cycle 0 -> m_valid cycle 7, m_result=12, m_count=1; mac_a=3 only in cycle 1.
2. [1,2,3]·[4,5,6], s_valid held high -> accepts cycles 0,2,4; s_ready low cycles 1,3,5+; m_result=32, m_count=3, m_valid cycle 11.
3. Same vector with 5 idle cycles between elements -> m_result=32 via psum path; mac_acc_in equals previous partial sum (4, then 14) in each stage-3 cycle.
4. Wrap: a=b=0xFFFF twice -> m_result=0xFFFC0002, m_count=2.
5. Backpressure: m_ready low 10 cycles -> m_valid/m_result stable, s_ready=0. m_ready high -> m_valid drops next cycle and s_ready=1 that cycle; next vector [7]·[6] -> 42, with no carry-over from the previous vector.
6. rst low for 2 cycles during DRAIN of [9]·[9] -> m_valid stays 0, s_ready=1 after release; then [2]·[5] -> m_result=10, m_count=1.
